// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the datapath register file.
// Decode and writeback import the same defaults so port widths stay in step.
package regfile_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

endpackage

// File: rtl/param_register_file_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Read addresses and data are flattened, with port p at slice p.
interface param_register_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, clr_req,
        input  rd_data, rd_valid, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
        output rd_data, rd_valid, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks a pointer over every entry, one per cycle,
// and pulses done for a single cycle once the last entry has been wiped.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clear_en,
    output logic [ADDR_W-1:0] clear_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        clear_en  = 1'b0;
        clear_idx = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                clear_en = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: one write port, NUM_RD combinational read ports,
// per-entry valid bits, optional same-cycle bypass and hardwired-zero entry 0.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    param_register_file_if.slave bus
);

    localparam int              ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]  entry_valid;
    logic              clear_en;
    logic [ADDR_W-1:0] clear_idx;
    logic              wr_in_range;
    logic              wr_to_zero;
    logic              wr_accept;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
    assign wr_to_zero  = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign wr_accept   = bus.wr_en && !bus.clr_busy && wr_in_range && !wr_to_zero;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (bus.clr_req),
        .clr_busy  (bus.clr_busy),
        .clr_done  (bus.clr_done),
        .clear_en  (clear_en),
        .clear_idx (clear_idx)
    );

    // Clear wins over write; the two never coincide because writes are blocked while busy.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(e);

        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              clr_hit;
        logic              wr_hit;

        assign clr_hit = clear_en && (clear_idx == IDX);
        assign wr_hit  = wr_accept && (bus.wr_addr == IDX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (clr_hit) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (wr_hit) begin
                data_q  <= bus.wr_data;
                valid_q <= 1'b1;
            end
        end

        assign entry_data[e]  = data_q;
        assign entry_valid[e] = valid_q;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              vld;
        logic              in_range;
        logic              is_zero;
        logic              hit;

        assign addr     = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign in_range = ({1'b0, addr} < DEPTH_EXT);
        assign is_zero  = (ZERO_REG != 0) && (addr == '0);
        assign hit      = (BYPASS != 0) && wr_accept && (bus.wr_addr == addr);

        always_comb begin
            data = '0;
            vld  = 1'b0;
            if (in_range && !is_zero) begin
                if (hit) begin
                    data = bus.wr_data;
                    vld  = 1'b1;
                end else begin
                    data = entry_data[addr];
                    vld  = entry_valid[addr];
                end
            end
        end

        assign bus.rd_data[p*DATA_W +: DATA_W] = data;
        assign bus.rd_valid[p]                 = vld;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench: dut_a is the default build (bypass on), dut_b has DEPTH=6,
// no bypass and a hardwired-zero entry 0.
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    param_register_file_if #(.DATA_W(12), .DEPTH(8), .NUM_RD(2)) bus_a ();
    param_register_file_if #(.DATA_W(12), .DEPTH(6), .NUM_RD(2)) bus_b ();

    param_register_file #(
        .DATA_W(12), .DEPTH(8), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    param_register_file #(
        .DATA_W(12), .DEPTH(6), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    string       q_name [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];

    // Selector: dut*8 + {0,1 data port; 2,3 valid port; 4 busy; 5 done}
    function automatic logic [31:0] actual(int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            0:  r = 32'(bus_a.rd_data[11:0]);
            1:  r = 32'(bus_a.rd_data[23:12]);
            2:  r = 32'(bus_a.rd_valid[0]);
            3:  r = 32'(bus_a.rd_valid[1]);
            4:  r = 32'(bus_a.clr_busy);
            5:  r = 32'(bus_a.clr_done);
            8:  r = 32'(bus_b.rd_data[11:0]);
            9:  r = 32'(bus_b.rd_data[23:12]);
            10: r = 32'(bus_b.rd_valid[0]);
            11: r = 32'(bus_b.rd_valid[1]);
            12: r = 32'(bus_b.clr_busy);
            13: r = 32'(bus_b.clr_done);
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        string       nm;
        int          sel;
        logic [31:0] exp_v;
        logic [31:0] act_v;
        while (q_sel.size() > 0) begin
            nm    = q_name.pop_front();
            sel   = q_sel.pop_front();
            exp_v = q_exp.pop_front();
            act_v = actual(sel);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit dut_sel_b, input logic we, input logic [2:0] wa,
                                 input logic [11:0] wd, input logic [2:0] ra0,
                                 input logic [2:0] ra1, input logic clr);
        if (!dut_sel_b) begin
            bus_a.wr_en   = we;
            bus_a.wr_addr = wa;
            bus_a.wr_data = wd;
            bus_a.rd_addr = {ra1, ra0};
            bus_a.clr_req = clr;
        end else begin
            bus_b.wr_en   = we;
            bus_b.wr_addr = wa;
            bus_b.wr_data = wd;
            bus_b.rd_addr = {ra1, ra0};
            bus_b.clr_req = clr;
        end
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp_v);
        q_name.push_back(name);
        q_sel.push_back(sel);
        q_exp.push_back(exp_v);
    endtask

    task automatic checkRead(input string name, input bit dut_sel_b, input int port,
                             input logic [11:0] d, input logic v);
        int base;
        base = dut_sel_b ? 8 : 0;
        checkOutput({name, "_data"}, base + port, 32'(d));
        checkOutput({name, "_valid"}, base + 2 + port, 32'(v));
    endtask

    task automatic checkClr(input string name, input bit dut_sel_b, input logic busy, input logic done);
        int base;
        base = dut_sel_b ? 8 : 0;
        checkOutput({name, "_busy"}, base + 4, 32'(busy));
        checkOutput({name, "_done"}, base + 5, 32'(done));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkClr("reset_a", 0, 0, 0);
        checkClr("reset_b", 1, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step();
            applyStimulus(0, 0, 0, 0, 3'(i), 3'(7 - i), 0);
            checkRead($sformatf("rst_p0_a%0d", i), 0, 0, 12'h000, 1'b0);
            checkRead($sformatf("rst_p1_a%0d", 7 - i), 0, 1, 12'h000, 1'b0);
        end

        step();
        applyStimulus(0, 1, 3'd5, 12'hABC, 3'd5, 3'd0, 0);
        checkRead("wr5_bypass", 0, 0, 12'hABC, 1'b1);
        checkRead("wr5_other", 0, 1, 12'h000, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 3'd5, 3'd4, 0);
        checkRead("rd5_stored", 0, 0, 12'hABC, 1'b1);
        checkRead("rd4_untouched", 0, 1, 12'h000, 1'b0);

        step();
        applyStimulus(0, 1, 3'd3, 12'h123, 3'd0, 3'd3, 0);
        applyStimulus(1, 1, 3'd3, 12'h123, 3'd0, 3'd3, 0);
        checkRead("bypass_on", 0, 1, 12'h123, 1'b1);
        checkRead("bypass_on_p0", 0, 0, 12'h000, 1'b0);
        checkRead("bypass_off", 1, 1, 12'h000, 1'b0);
        step();
        applyStimulus(0, 0, 0, 0, 3'd3, 3'd0, 0);
        applyStimulus(1, 0, 0, 0, 3'd3, 3'd0, 0);
        checkRead("rd3_a", 0, 0, 12'h123, 1'b1);
        checkRead("rd3_b", 1, 0, 12'h123, 1'b1);

        step();
        applyStimulus(1, 1, 3'd0, 12'hFFF, 3'd0, 3'd3, 0);
        checkRead("zero_wr_same", 1, 0, 12'h000, 1'b0);
        checkRead("zero_keep3", 1, 1, 12'h123, 1'b1);
        step();
        applyStimulus(1, 0, 0, 0, 3'd0, 3'd7, 0);
        checkRead("zero_rd0", 1, 0, 12'h000, 1'b0);
        checkRead("oor_rd7", 1, 1, 12'h000, 1'b0);
        step();
        applyStimulus(1, 1, 3'd7, 12'hAAA, 3'd7, 3'd5, 0);
        checkRead("oor_wr7_same", 1, 0, 12'h000, 1'b0);
        checkRead("oor_wr7_rd5", 1, 1, 12'h000, 1'b0);
        step();
        applyStimulus(1, 0, 0, 0, 3'd7, 3'd3, 0);
        checkRead("oor_after7", 1, 0, 12'h000, 1'b0);
        checkRead("oor_after3", 1, 1, 12'h123, 1'b1);
        step();
        applyStimulus(1, 0, 0, 0, 3'd6, 3'd1, 0);
        checkRead("oor_rd6", 1, 0, 12'h000, 1'b0);
        checkRead("oor_rd1", 1, 1, 12'h000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step();
            applyStimulus(0, 1, 3'(i), 12'h100 + 12'(i), 3'(i), 3'd0, 0);
            checkRead($sformatf("fill_%0d", i), 0, 0, 12'h100 + 12'(i), 1'b1);
        end

        step();
        applyStimulus(0, 1, 3'd1, 12'h777, 3'd1, 3'd0, 1);
        checkClr("clr_req_cycle", 0, 0, 0);
        checkRead("req_wr1_bypass", 0, 0, 12'h777, 1'b1);
        checkRead("req_rd0", 0, 1, 12'h100, 1'b1);

        for (int j = 1; j <= 8; j++) begin
            logic [11:0] old_v;
            old_v = (j - 1 == 1) ? 12'h777 : 12'h100 + 12'(j - 1);
            step();
            if (j == 2)
                applyStimulus(0, 1, 3'd2, 12'h555, 3'(j - 1), 3'(j - 2), 0);
            else
                applyStimulus(0, 0, 0, 0, 3'(j - 1), (j >= 2) ? 3'(j - 2) : 3'd0, 0);
            checkClr($sformatf("clr_cyc%0d", j), 0, 1, 0);
            checkRead($sformatf("clr_pend%0d", j - 1), 0, 0, old_v, 1'b1);
            if (j >= 2)
                checkRead($sformatf("clr_done%0d", j - 2), 0, 1, 12'h000, 1'b0);
            else
                checkRead("clr_first0", 0, 1, 12'h100, 1'b1);
        end

        step();
        applyStimulus(0, 1, 3'd4, 12'h2A5, 3'd7, 3'd4, 0);
        checkClr("done_cycle", 0, 0, 1);
        checkRead("done_rd7", 0, 0, 12'h000, 1'b0);
        checkRead("done_wr4", 0, 1, 12'h2A5, 1'b1);

        for (int i = 0; i < 8; i++) begin
            step();
            applyStimulus(0, 0, 0, 0, 3'(i), 3'(i), 0);
            if (i == 0) checkClr("after_done", 0, 0, 0);
            checkRead($sformatf("post_p0_%0d", i), 0, 0, (i == 4) ? 12'h2A5 : 12'h000, i == 4);
            checkRead($sformatf("post_p1_%0d", i), 0, 1, (i == 4) ? 12'h2A5 : 12'h000, i == 4);
        end

        step();
        applyStimulus(0, 1, 3'd6, 12'h3C3, 3'd6, 3'd0, 0);
        checkRead("pre_abort_wr6", 0, 0, 12'h3C3, 1'b1);
        step();
        applyStimulus(0, 0, 0, 0, 3'd6, 3'd0, 1);
        checkRead("pre_abort_rd6", 0, 0, 12'h3C3, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step();
            applyStimulus(0, 0, 0, 0, 3'd6, 3'd0, 0);
            checkClr($sformatf("abort_busy%0d", j), 0, 1, 0);
        end
        step();
        rst_n = 1'b0;
        applyStimulus(1, 0, 0, 0, 3'd3, 3'd0, 0);
        checkClr("abort_now", 0, 0, 0);
        checkRead("abort_rd6", 0, 0, 12'h000, 1'b0);
        checkRead("abort_b_rd3", 1, 0, 12'h000, 1'b0);
        step();
        checkClr("abort_hold", 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            checkClr($sformatf("abort_quiet%0d", j), 0, 0, 0);
        end

        step();
        applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 1);
        checkClr("fresh_req", 0, 0, 0);
        for (int j = 1; j <= 8; j++) begin
            step();
            applyStimulus(0, 0, 0, 0, 3'd0, 3'd0, 0);
            checkClr($sformatf("fresh_busy%0d", j), 0, 1, 0);
        end
        step();
        checkClr("fresh_done", 0, 0, 1);
        step();
        checkClr("fresh_idle", 0, 0, 0);

        @(negedge clk);
        #1;
        if (q_sel.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-read-port register file for the datapath. It generalises the 8×12-bit, two-read-port file to configurable width, depth and read-port count, and adds four features: asynchronous reset, optional write-to-read bypass, an optional hardwired-zero entry, and per-entry valid bits. A sequenced bulk-clear engine wipes the file one entry per cycle, so a pipeline flush can zero architectural state without a reset. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
- DATA_W, 12, bits per entry
- DEPTH, 8, number of entries (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- NUM_RD, 2, number of read ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- ZERO_REG, 0, 1 = entry 0 always reads 0, writes to it discarded
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W], combinational
- rd_valid  out  NUM_RD  entry written since last reset/clear, combinational
- clr_req  in  1  bulk-clear request, sampled only in IDLE
- clr_busy  out  1  clear in progress; writes are ignored while high
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- Write accept: wr_en & !clr_busy & wr_addr<DEPTH & !(ZERO_REG & wr_addr==0).
- An accepted write updates the entry and sets its valid bit at the next edge. Rejected writes have no effect and no indication.
- Read port p:
  - ZERO_REG entry 0 or rd_addr≥DEPTH: data 0, valid 0.
  - Otherwise, if BYPASS and the write accepts this cycle at the same address: data wr_data, valid 1.
  - Otherwise: stored data and valid bit.
- All read ports are independent. Identical addresses return identical results.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR when clr_req=1; the pointer loads 0.
  - CLEAR: each cycle, zero entry[ptr] data and valid, then ptr++. After ptr==DEPTH-1 is cleared, go to DONE.
  - DONE→IDLE unconditionally.
  - clr_req is ignored in CLEAR and DONE.
- clr_busy = (state==CLEAR); clr_done = (state==DONE).
- In the request cycle (IDLE, clr_req=1), a simultaneous write is accepted and is later zeroed by the clear.
- Reads during CLEAR return current contents. Already-cleared entries read 0/invalid.
- Reset values: all entries 0, all valid bits 0, state IDLE, ptr 0, clr_busy 0, clr_done 0.
- Reset asserted mid-clear aborts to IDLE immediately. No clr_done pulse is produced.

## Timing
- Write latency: visible via storage 1 cycle after the accepting edge, or in the same cycle via bypass when BYPASS=1.
- Read path is purely combinational: address to data with no register.
- Clear with clr_req sampled high at edge k:
  - clr_busy high from edge k+1 through edge k+DEPTH.
  - clr_done high between edges k+DEPTH and k+DEPTH+1.
  - Writes are accepted again from edge k+DEPTH onward (during the DONE cycle).
- Minimum clr_req-to-next-accepted-clr_req spacing: DEPTH+2 cycles.
- rst_n deassertion is assumed synchronised upstream. The first write is accepted at the first edge after release.

## Structure
- Package regfile_pkg holds:
  - typedef enum clr_state_t {IDLE, CLEAR, DONE}
  - default DATA_W/DEPTH constants shared with decode/writeback
- Sub-module regfile_clear_fsm owns the state, ptr, clr_busy and clr_done. It outputs clear_en and clear_idx to the storage.
- Top level contains:
  - storage array with per-entry write/clear enables; clear has priority, and cannot collide since writes are blocked during CLEAR
  - valid-bit vector
  - NUM_RD generated read muxes with bypass compare

## Test plan
- Reset then read all entries on both ports → data 0, rd_valid 0. Write 0xABC to addr 5, read addr 5 next cycle → 0xABC, valid 1.
- BYPASS=1: write 0x123 to addr 3 while port 1 reads addr 3 in the same cycle → rd_data 0x123, valid 1. With BYPASS=0, the same stimulus returns the old value 0x000 / valid 0.
- ZERO_REG=1: write 0xFFF to addr 0 → reads 0, valid 0. DEPTH=6: read addr 7 → 0/0, and a write to addr 7 changes nothing.
- Fill all 8 entries, pulse clr_req at edge k → clr_busy for 8 cycles, clr_done at edge k+8. A write of 0x555 to addr 2 during busy is dropped. At the end, all entries read 0/invalid.
- Request cycle: clr_req together with a write of 0x777 to addr 1 → 0x777 readable in cycle k+1, then zero after entry 1 is cleared.
- Reset mid-clear: assert rst_n=0 during CLEAR → clr_busy drops immediately, no clr_done, all entries 0; a new clr_req after release starts a fresh clear.
